// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block handshake and round-datapath strobes of the AES-128 round sequencer
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       dp_load;
    logic       dp_round;
    logic       dp_last;
    logic [3:0] round_idx;
    logic [7:0] rcon;
    logic       busy;
    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, dp_load, dp_round, dp_last, round_idx, rcon, busy
    );
    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, dp_load, dp_round, dp_last, round_idx, rcon, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer driving one shared round datapath through
// the initial AddRoundKey and NR rounds, with valid/ready block input and held result output.
module aes_round_ctrl #(
    parameter int ROUND_CYCLES = 1,
    parameter int NR           = 10
) (
    input logic            clk,
    input logic            rst,
    aes_round_ctrl_if.slave bus
);
    localparam int SW = ROUND_CYCLES > 1 ? $clog2(ROUND_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t        state, state_nx;
    logic [SW-1:0] sub, sub_nx;
    logic [3:0]    ridx, ridx_nx;
    logic [7:0]    rc, rc_nx;
    logic          accept, step, final_step;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sub   <= '0;
            ridx  <= '0;
            rc    <= 8'h01;
        end else begin
            state <= state_nx;
            sub   <= sub_nx;
            ridx  <= ridx_nx;
            rc    <= rc_nx;
        end
    end
    // in_ready looks through to out_ready so a new block can enter as the result leaves
    always_comb begin
        bus.in_ready  = !rst && (state == IDLE || (state == DONE && bus.out_ready));
        accept        = bus.in_valid && bus.in_ready;
        step          = state == ROUND && sub == SW'(ROUND_CYCLES - 1);
        final_step    = step && ridx == 4'(NR);
        bus.dp_load   = accept;
        bus.dp_round  = !rst && step;
        bus.dp_last   = !rst && state == ROUND && ridx == 4'(NR);
        bus.out_valid = !rst && state == DONE;
        bus.busy      = !rst && state != IDLE;
        bus.round_idx = rst ? 4'd0 : ridx;
        bus.rcon      = rst ? 8'd0 : rc;
        state_nx      = accept ? ROUND : final_step ? DONE :
                        (state == DONE && bus.out_ready) ? IDLE : state;
        sub_nx        = (accept || step) ? '0 : state == ROUND ? sub + 1'b1 : sub;
        ridx_nx       = accept ? 4'd1 : final_step ? 4'd0 : step ? ridx + 4'd1 : ridx;
        rc_nx         = accept ? 8'h01 :
                        (step && !final_step) ? {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00) : rc;
    end
endmodule
